round_share_arb: RTL and testbench
==================================

ROUND_SHARE_ARB -- requirements
Module: round_share_arb

Interface
REQ-001 Parameter NUM, default 4, number of requesters sharing one round-half-up unit (2..8).
REQ-002 Parameter DIN, default 16, data width of every stream.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port din[NUM]  dti.consumer  DIN  per-requester input streams.
REQ-006 Port dout[NUM]  dti.producer  DIN  per-requester rounded result streams, index-matched to din.
REQ-007 Port cfg_nbits[NUM]  input  $clog2(DIN) each  per-requester count of low bits rounded away; sampled at grant.

Function
REQ-008 Block SHALL hold one output register (data, owner index, valid) with two states: EMPTY, FULL.
REQ-009 EMPTY -> FULL when any din[i].valid is high; the granted requester's handshake completes that cycle.
REQ-010 FULL -> EMPTY when dout[owner] handshakes and no din is valid; FULL -> FULL (new load) when dout[owner] handshakes and some din is valid, giving one result per cycle sustained.
REQ-011 Grant SHALL be round-robin: search starts at the index after the last granted requester, wrapping NUM-1 -> 0.
REQ-012 din[i].ready SHALL be high only for the granted index, and only when the register is EMPTY or being drained that cycle.
REQ-013 dout[i].valid SHALL be high only when FULL and i == owner; dout[i].data SHALL equal the register data for all i.
REQ-014 Latency SHALL be exactly one cycle from din handshake to dout valid; no combinational path from din.data to dout.data.
REQ-015 Result: sum = din + 2^(n-1) modulo 2^DIN, then low n bits cleared, with n = cfg_nbits[grant].
REQ-016 n == 0 SHALL pass data through unchanged; n >= DIN is illegal and SHALL be treated as DIN-1.
REQ-017 Default (macro absent) overflow SHALL wrap, e.g. DIN=16, n=4: 0xFFF8 -> 0x0000.
REQ-018 dout[owner] backpressure SHALL hold data, owner and valid stable; no other requester is granted until drain.
REQ-019 cfg_nbits changes while FULL SHALL not affect the held result.

Reset
REQ-020 On rst low, register SHALL go EMPTY, data 0, owner 0, round-robin pointer set so requester 0 has highest priority, asynchronously.
REQ-021 All dout[i].valid and din[i].ready SHALL be 0 during reset; an in-flight result is discarded.
REQ-022 First grant after reset deassertion SHALL occur no earlier than the first rising edge with rst high.

Configuration
REQ-023 Macro ROUND_SHARE_SAT_EN defined: carry out of the add SHALL saturate the result to all-ones with low n bits cleared (0xFFF8, n=4 -> 0xFFF0).
REQ-024 Macro absent: wrap behaviour per REQ-017; no saturation logic synthesised.

Structure
REQ-025 Package round_share_pkg SHALL hold: MAX_NUM constant, ch_idx_t (owner/pointer index type), state enum {EMPTY, FULL}.
REQ-026 Round-robin selection SHALL be a separate sub-module rr_arbiter (request vector, enable, last-grant in; one-hot grant and index out).
REQ-027 Rounding arithmetic SHALL be inline in round_share_arb.

Verification
REQ-028 DIN=16, single requester 0, n=4, din 0x0018 then 0x0017 -> dout[0] 0x0020 then 0x0010, each one cycle after handshake.
REQ-029 All 4 requesters valid continuously, all dout ready -> grants 0,1,2,3,0,... one per cycle, each dout[i] sees only its own results.
REQ-030 Requester 2 owns register, dout[2].ready low 5 cycles -> data/owner stable, all din.ready low, then resumes with grant 3.
REQ-031 din 0xFFF8, n=4 -> 0x0000 without ROUND_SHARE_SAT_EN, 0xFFF0 with it; n=0, din 0x1234 -> 0x1234.
REQ-032 rst asserted while FULL with dout ready low -> dout valid drops immediately; after release requester 0 granted first when 0 and 3 both valid.

Source files
------------

// File: rtl/round_share_pkg.sv
// Shared types for the round-half-up sharing block.
//   MAX_NUM  : largest supported requester count
//   ch_idx_t : requester index (owner / round-robin pointer)
//   state_t  : output register occupancy
package round_share_pkg;

  localparam int unsigned MAX_NUM = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_NUM);

  typedef logic [IDX_W-1:0] ch_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/round_share_arb_if.sv
// Valid/ready data stream interface.
//   valid : producer has data this cycle
//   ready : consumer accepts data this cycle
//   data  : W-bit payload
// producer/master drive valid+data, consumer/slave drive ready.
interface dti #(
  parameter int unsigned W = 16
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
  modport master   (output valid, output data, input ready);
  modport slave    (input valid, input data, output ready);

endinterface

// File: rtl/round_share_arb_rr_arbiter.sv
// Round-robin requester selection.
//   req   : request vector
//   en    : grant allowed this cycle
//   last  : index of the most recent grant; search starts just after it
//   gnt_c : one-hot grant (all zero when en low or no request)
//   idx_c : index of the granted requester
//   any_c : a grant was issued
module rr_arbiter
  import round_share_pkg::*;
#(
  parameter int unsigned NUM = 4
) (
  input  logic [NUM-1:0] req,
  input  logic           en,
  input  ch_idx_t        last,
  output logic [NUM-1:0] gnt_c,
  output ch_idx_t        idx_c,
  output logic           any_c
);

  // First pass covers indices above last, second pass wraps to 0.
  always_comb begin
    logic found;
    found = 1'b0;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int i = 0; i < int'(NUM); i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        found    = 1'b1;
        gnt_c[i] = 1'b1;
        idx_c    = ch_idx_t'(i);
      end
    end
    for (int i = 0; i < int'(NUM); i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        gnt_c[i] = 1'b1;
        idx_c    = ch_idx_t'(i);
      end
    end
    if (en) begin
      any_c = found;
    end else begin
      gnt_c = '0;
    end
  end

endmodule

// File: rtl/round_share_arb.sv
// NUM requesters share one round-half-up unit and a single output register.
// A granted word is rounded (add 2^(n-1), clear low n bits) and held in the
// register until the owning output stream accepts it; a new grant may load
// in the same cycle the register drains.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   din[i]    : input streams (consumer side)
//   dout[i]   : result streams, index-matched to din
//   cfg_nbits : per-requester count of low bits rounded away, sampled at grant
// Build option: ROUND_SHARE_SAT_EN saturates on carry out instead of wrapping.
module round_share_arb
  import round_share_pkg::*;
#(
  parameter int unsigned NUM = 4,
  parameter int unsigned DIN = 16
) (
  input logic                    clk,
  input logic                    rst,
  dti.consumer                   din       [NUM],
  dti.producer                   dout      [NUM],
  input logic [$clog2(DIN)-1:0]  cfg_nbits [NUM]
);

  localparam int unsigned NBW = $clog2(DIN);

  state_t         state_q;
  logic [DIN-1:0] data_q;
  ch_idx_t        owner_q;
  ch_idx_t        last_q;

  logic [NUM-1:0] in_valid_c;
  logic [NUM-1:0] in_ready_c;
  logic [NUM-1:0] out_ready_c;
  logic [NUM-1:0] out_valid_c;
  logic [DIN-1:0] in_data_c [NUM];

  logic           owner_ready_c;
  logic           drain_c;
  logic           load_en_c;
  logic [NUM-1:0] gnt_c;
  ch_idx_t        gnt_idx_c;
  logic           load_c;

  logic [DIN-1:0] sel_data_c;
  logic [NBW-1:0] sel_n_c;
  logic [NBW-1:0] n_c;
  logic [DIN-1:0] half_c;
  logic [DIN-1:0] mask_c;
  logic [DIN-1:0] sum_c;
  logic [DIN-1:0] rnd_c;
`ifdef ROUND_SHARE_SAT_EN
  logic           carry_c;
`endif

  // Flatten the interface arrays; every result stream sees the register data.
  for (genvar g = 0; g < NUM; g++) begin : g_port
    assign in_valid_c[g]  = din[g].valid;
    assign in_data_c[g]   = din[g].data;
    assign din[g].ready   = in_ready_c[g];
    assign out_ready_c[g] = dout[g].ready;
    assign out_valid_c[g] = (state_q == FULL) && (owner_q == ch_idx_t'(g));
    assign dout[g].valid  = out_valid_c[g];
    assign dout[g].data   = data_q;
  end

  // Ready of the current owner's output stream.
  always_comb begin
    owner_ready_c = 1'b0;
    for (int i = 0; i < int'(NUM); i++) begin
      if (owner_q == ch_idx_t'(i)) begin
        owner_ready_c = out_ready_c[i];
      end
    end
  end

  assign drain_c   = (state_q == FULL) && owner_ready_c;
  // No grant while reset is held, so nothing is accepted before the first live edge.
  assign load_en_c = rst && ((state_q == EMPTY) || drain_c);

  rr_arbiter #(
    .NUM (NUM)
  ) u_rr (
    .req   (in_valid_c),
    .en    (load_en_c),
    .last  (last_q),
    .gnt_c (gnt_c),
    .idx_c (gnt_idx_c),
    .any_c (load_c)
  );

  assign in_ready_c = gnt_c;

  // Select the granted word and its rounding amount from the one-hot grant.
  always_comb begin
    sel_data_c = '0;
    sel_n_c    = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      if (gnt_c[i]) begin
        sel_data_c = in_data_c[i];
        sel_n_c    = cfg_nbits[i];
      end
    end
  end

  // Round half up: add 2^(n-1), clear low n bits; n clamped to DIN-1.
  always_comb begin
    n_c    = (32'(sel_n_c) >= DIN) ? NBW'(DIN - 1) : sel_n_c;
    half_c = (n_c == '0) ? '0 : (DIN'(1) << (n_c - NBW'(1)));
    mask_c = ~((DIN'(1) << n_c) - DIN'(1));
`ifdef ROUND_SHARE_SAT_EN
    {carry_c, sum_c} = {1'b0, sel_data_c} + {1'b0, half_c};
    rnd_c = carry_c ? mask_c : (sum_c & mask_c);
`else
    sum_c = sel_data_c + half_c;
    rnd_c = sum_c & mask_c;
`endif
  end

  // Output register: load on grant, empty on drain without a new grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      owner_q <= '0;
      last_q  <= ch_idx_t'(NUM - 1);
    end else if (load_c) begin
      state_q <= FULL;
      data_q  <= rnd_c;
      owner_q <= gnt_idx_c;
      last_q  <= gnt_idx_c;
    end else if (drain_c) begin
      state_q <= EMPTY;
    end
  end

endmodule

// File: tb/tb_round_share_arb.sv
// Directed bench for round_share_arb (NUM=4, DIN=16): reset, round-robin
// streaming, single-requester rounding, overflow/pass-through/clamp corners,
// owner backpressure, and reset while a result is held.
module tb_round_share_arb;

  localparam int unsigned NUM = 4;
  localparam int unsigned DIN = 16;

`ifdef ROUND_SHARE_SAT_EN
  localparam logic [DIN-1:0] EXP_OVF4  = 16'hFFF0;
  localparam logic [DIN-1:0] EXP_OVF15 = 16'h8000;
`else
  localparam logic [DIN-1:0] EXP_OVF4  = 16'h0000;
  localparam logic [DIN-1:0] EXP_OVF15 = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [NUM-1:0] tv;
  logic [NUM-1:0] trdy;
  logic [NUM-1:0] o_valid;
  logic [NUM-1:0] i_ready;
  logic [DIN-1:0] td     [NUM];
  logic [DIN-1:0] o_data [NUM];
  logic [3:0]     cfg    [NUM];

  dti #(.W(DIN)) din_if  [NUM] ();
  dti #(.W(DIN)) dout_if [NUM] ();

  for (genvar g = 0; g < NUM; g++) begin : g_tb
    assign din_if[g].valid  = tv[g];
    assign din_if[g].data   = td[g];
    assign dout_if[g].ready = trdy[g];
    assign i_ready[g]       = din_if[g].ready;
    assign o_valid[g]       = dout_if[g].valid;
    assign o_data[g]        = dout_if[g].data;
  end

  round_share_arb #(
    .NUM (NUM),
    .DIN (DIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din_if),
    .dout      (dout_if),
    .cfg_nbits (cfg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One requester-0 word through the rounder, result checked one cycle later.
  task automatic round_one(input string tag, input logic [DIN-1:0] d,
                           input logic [3:0] n, input logic [DIN-1:0] exp);
    @(negedge clk);
    tv     = 4'b0001;
    td[0]  = d;
    cfg[0] = n;
    tick();
    chk({tag, "_valid"}, 32'(o_valid), 32'(4'b0001));
    chk({tag, "_data"}, 32'(o_data[0]), 32'(exp));
  endtask

  initial begin
    int e;
    rst  = 1'b0;
    tv   = '1;
    trdy = '1;
    for (int i = 0; i < int'(NUM); i++) begin
      td[i]  = '0;
      cfg[i] = '0;
    end

    // Reset: nothing offered, nothing accepted even with all din valid.
    #12;
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_ready", 32'(i_ready), 32'(0));
    chk("rst_data", 32'(o_data[1]), 32'(0));

    // All requesters streaming, all outputs ready: 0,1,2,3,0,... one per cycle.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < int'(NUM); i++) td[i] = DIN'(16'hA000 + i);
    #1;
    chk("rr_first_ready", 32'(i_ready), 32'(4'b0001));
    for (int k = 0; k < 8; k++) begin
      e = k % 4;
      tick();
      chk("rr_valid", 32'(o_valid), 32'(4'b0001 << e));
      chk("rr_data", 32'(o_data[e]), 32'(16'hA000 + e));
      chk("rr_shared_data", 32'(o_data[(e + 2) % 4]), 32'(16'hA000 + e));
      chk("rr_next_ready", 32'(i_ready), 32'(4'b0001 << ((e + 1) % 4)));
    end
    @(negedge clk);
    tv = '0;
    tick();
    chk("rr_drained", 32'(o_valid), 32'(0));

    // Single requester, n=4, back-to-back words.
    round_one("n4_a", 16'h0018, 4'd4, 16'h0020);
    chk("n4_a_ready", 32'(i_ready), 32'(4'b0001));
    round_one("n4_b", 16'h0017, 4'd4, 16'h0010);
    // Overflow, pass-through, small n, largest legal n.
    round_one("ovf4", 16'hFFF8, 4'd4, EXP_OVF4);
    round_one("pass0", 16'h1234, 4'd0, 16'h1234);
    round_one("n2", 16'h0006, 4'd2, 16'h0008);
    round_one("n15", 16'h4000, 4'd15, 16'h8000);
    round_one("ovf15", 16'hC000, 4'd15, EXP_OVF15);
    @(negedge clk);
    tv = '0;
    tick();
    chk("single_drained", 32'(o_valid), 32'(0));

    // Requester 2 owns the register while its output stalls.
    @(negedge clk);
    cfg[2] = 4'd4;
    td[2]  = 16'h0125;
    tv     = 4'b0100;
    trdy   = 4'b1011;
    #1;
    chk("bp_grant2", 32'(i_ready), 32'(4'b0100));
    tick();
    chk("bp_valid", 32'(o_valid), 32'(4'b0100));
    chk("bp_data", 32'(o_data[2]), 32'(16'h0120));
    @(negedge clk);
    tv     = 4'b1011;
    td[0]  = 16'h1111;
    td[1]  = 16'h2222;
    td[3]  = 16'h3333;
    cfg[0] = 4'd0;
    cfg[1] = 4'd0;
    cfg[2] = 4'd0;
    cfg[3] = 4'd0;
    #1;
    chk("bp_ready_low", 32'(i_ready), 32'(0));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 32'(o_valid), 32'(4'b0100));
      chk("bp_hold_data", 32'(o_data[2]), 32'(16'h0120));
      chk("bp_hold_ready", 32'(i_ready), 32'(0));
    end
    @(negedge clk);
    trdy = '1;
    #1;
    chk("bp_resume_grant3", 32'(i_ready), 32'(4'b1000));
    tick();
    chk("bp_resume_valid", 32'(o_valid), 32'(4'b1000));
    chk("bp_resume_data", 32'(o_data[3]), 32'(16'h3333));
    chk("bp_after3_ready", 32'(i_ready), 32'(4'b0001));
    @(negedge clk);
    tv = '0;
    tick();
    chk("bp_drained", 32'(o_valid), 32'(0));

    // Reset while a result is held and its output is stalled.
    @(negedge clk);
    trdy  = '0;
    tv    = 4'b0100;
    td[2] = 16'h0077;
    tick();
    chk("rf_valid", 32'(o_valid), 32'(4'b0100));
    chk("rf_data", 32'(o_data[2]), 32'(16'h0077));
    @(negedge clk);
    tv    = 4'b1001;
    td[0] = 16'h0BEE;
    td[3] = 16'h0DAD;
    #1;
    chk("rf_stalled_ready", 32'(i_ready), 32'(0));
    #2;
    rst = 1'b0;
    #1;
    chk("rf_async_valid", 32'(o_valid), 32'(0));
    chk("rf_async_ready", 32'(i_ready), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rf_first_grant0", 32'(i_ready), 32'(4'b0001));
    tick();
    chk("rf_load_valid", 32'(o_valid), 32'(4'b0001));
    chk("rf_load_data", 32'(o_data[0]), 32'(16'h0BEE));
    chk("rf_load_ready", 32'(i_ready), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
